// File: rtl/rv32i_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
// Opcodes, FSM states, ALU operations, immediate formats and selects.
package rv32i_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ,
    S_MEM_WB, S_MEM_WRITE, S_EXEC_R, S_EXEC_I,
    S_ALU_WB, S_BRANCH, S_JAL, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010, ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100, ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110, ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000, ALU_SRA  = 4'b1001
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001,
    IMM_B = 3'b010, IMM_J = 3'b011
  } imm_e;

  typedef enum logic {CLS_R, CLS_I} alu_class_e;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;
  localparam logic [1:0] A_PC       = 2'b00;
  localparam logic [1:0] A_OLDPC    = 2'b01;
  localparam logic [1:0] A_RS1      = 2'b10;
  localparam logic [1:0] B_RS2      = 2'b00;
  localparam logic [1:0] B_IMM      = 2'b01;
  localparam logic [1:0] B_FOUR     = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps func3 / func7[5] and instruction class to an ALU operation.
// func7[5] picks SUB only for register ops, SRA for both classes.
module alu_decoder
  import rv32i_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       func7_5,
  input  alu_class_e cls,
  output alu_op_e    alu_op
);

  // func3 selects the operation family, func7[5] the variant
  always_comb begin
    alu_op = ALU_ADD;
    case (func3)
      3'b000: alu_op = (func7_5 && cls == CLS_R) ? ALU_SUB : ALU_ADD;
      3'b001: alu_op = ALU_SLL;
      3'b010: alu_op = ALU_SLT;
      3'b011: alu_op = ALU_SLTU;
      3'b100: alu_op = ALU_XOR;
      3'b101: alu_op = func7_5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_op = ALU_OR;
      3'b111: alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_control.sv
// Multi-cycle RV32I control FSM with memory handshake, traps
// and a retired-instruction counter.
module rv32i_mc_control
  import rv32i_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op_code,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic             mem_read,
  output logic             adr_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [2:0]       imm_type,
  output logic [3:0]       alu_control,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_e      state, next;
  logic [WAIT_W-1:0] wait_cnt;
  logic        mem_state, timeout, retire;
  logic        pc_w, ir_w, reg_w, mem_w, mem_r;
  alu_class_e  cls;
  alu_op_e     dec_op;
  logic        unused_func7;

  assign unused_func7 = ^{func7[6], func7[4:0]};
  assign cls = (state == S_EXEC_R) ? CLS_R : CLS_I;

  alu_decoder u_alu_dec (
    .func3   (func3),
    .func7_5 (func7[5]),
    .cls     (cls),
    .alu_op  (dec_op)
  );

  assign mem_state = state inside {S_FETCH, S_MEM_READ, S_MEM_WRITE};
  assign timeout = mem_state && !mem_ready
                && (int'(wait_cnt) + 1 >= MAX_WAIT);
  assign retire = (next == S_FETCH)
               && (state inside {S_MEM_WB, S_MEM_WRITE,
                                 S_ALU_WB, S_BRANCH, S_JAL});

  // Next-state selection, including handshake waits and traps
  always_comb begin
    next = state;
    case (state)
      S_FETCH:
        if (mem_ready)    next = S_DECODE;
        else if (timeout) next = S_TRAP;
      S_DECODE:
        case (op_code)
          OP_LW, OP_SW: next = S_MEM_ADDR;
          OP_R:         next = S_EXEC_R;
          OP_I:         next = S_EXEC_I;
          OP_BR:  next = (func3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:       next = S_JAL;
          default:      next = S_TRAP;
        endcase
      S_MEM_ADDR:
        next = (op_code == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:
        if (mem_ready)    next = S_MEM_WB;
        else if (timeout) next = S_TRAP;
      S_MEM_WRITE:
        if (mem_ready)    next = S_FETCH;
        else if (timeout) next = S_TRAP;
      S_EXEC_R, S_EXEC_I:
        next = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL:
        next = S_FETCH;
      S_TRAP:
        next = S_TRAP;
      default:
        next = S_FETCH;
    endcase
  end

  // State, wait counter, retire counter and sticky trap flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      instret   <= '0;
      illegal   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state <= next;
      if (next != state)
        wait_cnt <= '0;
      else if (mem_state && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if (retire)
        instret <= instret + CNT_W'(1);
      if (state == S_DECODE && next == S_TRAP)
        illegal <= 1'b1;
      if (timeout)
        bus_error <= 1'b1;
    end
  end

  // Per-state datapath controls; fetch and branch writes are Mealy
  always_comb begin
    pc_w        = 1'b0;
    ir_w        = 1'b0;
    reg_w       = 1'b0;
    mem_w       = 1'b0;
    mem_r       = 1'b0;
    adr_src     = ADR_PC;
    alu_src_a   = A_PC;
    alu_src_b   = B_RS2;
    result_src  = RES_ALUOUT;
    imm_type    = IMM_I;
    alu_control = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_r      = 1'b1;
        alu_src_b  = B_FOUR;
        result_src = RES_ALU;
        ir_w       = mem_ready;
        pc_w       = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        imm_type  = (op_code == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEM_ADDR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        imm_type  = (op_code == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEM_READ: begin
        mem_r   = 1'b1;
        adr_src = ADR_ALUOUT;
      end
      S_MEM_WB: begin
        result_src = RES_MEM;
        reg_w      = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_w   = 1'b1;
        adr_src = ADR_ALUOUT;
      end
      S_EXEC_R: begin
        alu_src_a   = A_RS1;
        alu_src_b   = B_RS2;
        alu_control = dec_op;
      end
      S_EXEC_I: begin
        alu_src_a   = A_RS1;
        alu_src_b   = B_IMM;
        alu_control = dec_op;
      end
      S_ALU_WB: reg_w = 1'b1;
      S_BRANCH: begin
        alu_src_a   = A_RS1;
        alu_control = ALU_SUB;
        pc_w        = zero ^ func3[0];
      end
      S_JAL: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_FOUR;
        imm_type  = IMM_J;
        reg_w     = 1'b1;
        pc_w      = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_write  = pc_w  & ~rst;
  assign ir_write  = ir_w  & ~rst;
  assign reg_write = reg_w & ~rst;
  assign mem_write = mem_w & ~rst;
  assign mem_read  = mem_r & ~rst;

endmodule

// File: tb/tb_rv32i_mc_control.sv
// Randomized bench for rv32i_mc_control: each instruction is expanded
// into its expected per-cycle control outputs and compared every cycle.
module tb_rv32i_mc_control;

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [31:0] ALU_TAB =
    {4'd2, 4'd3, 4'd8, 4'd4, 4'd6, 4'd5, 4'd7, 4'd0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op_code = '0;
  logic [2:0] func3 = '0;
  logic [6:0] func7 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, reg_write, mem_write, mem_read;
  logic       adr_src;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_type;
  logic [3:0] alu_control;
  logic       illegal, bus_error;
  logic [1:0] instret;

  always #5 clk = ~clk;

  rv32i_mc_control #(.MAX_WAIT(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .func3(func3),
    .func7(func7), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_write(mem_write),
    .mem_read(mem_read), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_type(imm_type),
    .alu_control(alu_control), .illegal(illegal),
    .bus_error(bus_error), .instret(instret)
  );

  typedef struct {
    logic       rdy;
    logic [4:0] en;
    logic       adr;
    logic [1:0] a, b, res;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       ill, berr;
    logic [1:0] cnt;
  } cyc_t;

  cyc_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cnt_m = 0;
  bit ill_m = 0;
  bit berr_m = 0;
  logic [1:0] first_instret;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h",
               nm, cyc, act, exp);
    end
  endfunction

  function automatic cyc_t blank();
    cyc_t c;
    c.rdy = 1'($urandom_range(0, 1));
    c.en = '0; c.adr = 1'b0;
    c.a = '0; c.b = '0; c.res = '0;
    c.imm = '0; c.alu = '0;
    c.ill = ill_m; c.berr = berr_m;
    c.cnt = 2'(cnt_m);
    return c;
  endfunction

  function automatic logic [3:0] alu_of(bit is_r, logic [2:0] f3,
                                        logic f75);
    logic [3:0] r;
    r = ALU_TAB[f3*4 +: 4];
    if (f75 && f3 == 3'd5) r = 4'd9;
    if (f75 && f3 == 3'd0 && is_r) r = 4'd1;
    return r;
  endfunction

  task automatic trap(int n);
    for (int i = 0; i < n; i++) q.push_back(blank());
  endtask

  // A memory access: waits with the request held, then completion
  task automatic mem_acc(int waits, logic [4:0] en_w, logic [4:0] en_r,
                         logic adr, bit fetch);
    cyc_t c;
    for (int i = 0; i < waits; i++) begin
      c = blank(); c.rdy = 1'b0; c.en = en_w; c.adr = adr;
      if (fetch) begin c.b = 2'd2; c.res = 2'd2; end
      q.push_back(c);
    end
    c = blank(); c.rdy = 1'b1; c.en = en_r; c.adr = adr;
    if (fetch) begin c.b = 2'd2; c.res = 2'd2; end
    q.push_back(c);
  endtask

  task automatic build(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                       logic z, int fw, int mw);
    cyc_t c;
    bit legal;
    if (fw >= 4) begin
      for (int i = 0; i < 4; i++) begin
        c = blank(); c.rdy = 1'b0; c.en = 5'b00001;
        c.b = 2'd2; c.res = 2'd2; q.push_back(c);
      end
      berr_m = 1; trap(12); return;
    end
    mem_acc(fw, 5'b00001, 5'b11001, 1'b0, 1);
    c = blank(); c.a = 2'd1; c.b = 2'd1;
    c.imm = (op == JL) ? 3'd3 : 3'd2;
    q.push_back(c);
    legal = (op inside {LW, SW, RT, IT, JL})
         || (op == BR && f3[2:1] == 2'b00);
    if (!legal) begin ill_m = 1; trap(12); return; end
    c = blank();
    case (op)
      LW: begin
        c.a = 2'd2; c.b = 2'd1; q.push_back(c);
        mem_acc(mw, 5'b00001, 5'b00001, 1'b1, 0);
        c = blank(); c.res = 2'd1; c.en = 5'b00100; q.push_back(c);
      end
      SW: begin
        c.a = 2'd2; c.b = 2'd1; c.imm = 3'd1; q.push_back(c);
        mem_acc(mw, 5'b00010, 5'b00010, 1'b1, 0);
      end
      RT, IT: begin
        c.a = 2'd2; c.b = (op == IT) ? 2'd1 : 2'd0;
        c.alu = alu_of(op == RT, f3, f7[5]); q.push_back(c);
        c = blank(); c.en = 5'b00100; q.push_back(c);
      end
      BR: begin
        c.a = 2'd2; c.alu = 4'd1;
        c.en = {z ^ f3[0], 4'b0000}; q.push_back(c);
      end
      default: begin
        c.a = 2'd1; c.b = 2'd2; c.imm = 3'd3;
        c.en = 5'b10100; q.push_back(c);
      end
    endcase
    cnt_m = (cnt_m + 1) % 4;
  endtask

  task automatic compare(cyc_t e);
    chk("enables", {pc_write, ir_write, reg_write, mem_write, mem_read},
        e.en);
    chk("selects", {adr_src, alu_src_a, alu_src_b, result_src},
        {e.adr, e.a, e.b, e.res});
    chk("alu_imm", {alu_control, imm_type}, {e.alu, e.imm});
    chk("traps", {illegal, bus_error}, {e.ill, e.berr});
    chk("instret", instret, e.cnt);
  endtask

  task automatic exec(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                      logic z, int keep);
    cyc_t e;
    bit first = 1;
    while (q.size() > keep) begin
      e = q.pop_front();
      @(posedge clk); #1;
      rst = 1'b0; op_code = op; func3 = f3; func7 = f7;
      zero = z; mem_ready = e.rdy;
      @(negedge clk);
      cyc++;
      if (first) first_instret = instret;
      first = 0;
      compare(e);
    end
  endtask

  task automatic run(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                     logic z, int fw, int mw, output int len);
    build(op, f3, f7, z, fw, mw);
    len = q.size();
    exec(op, f3, f7, z, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0;
    cnt_m = 0; ill_m = 0; berr_m = 0;
    @(negedge clk);
    chk("reset_en", {pc_write, ir_write, reg_write, mem_write, mem_read},
        5'b0);
    chk("reset_flags", {illegal, bus_error, instret}, 4'b0);
  endtask

  initial begin
    int len;
    logic [6:0] ops[6];
    logic [6:0] op;
    logic [2:0] f3;
    cyc_t e;
    ops = '{LW, SW, RT, IT, BR, JL};

    do_reset();
    run(LW, 3'd2, 7'd0, 1'b0, 0, 0, len);
    chk("lw_cycles", len, 5);
    run(SW, 3'd2, 7'd0, 1'b0, 0, 3, len);
    chk("sw_wait_cycles", len, 7);
    chk("instret_after_lw", first_instret, 2'd1);
    run(BR, 3'd0, 7'd0, 1'b1, 0, 0, len);
    chk("br_cycles", len, 3);
    run(BR, 3'd1, 7'd0, 1'b1, 0, 0, len);
    run(RT, 3'd0, 7'b0100000, 1'b0, 0, 0, len);
    chk("r_cycles", len, 4);
    run(IT, 3'd0, 7'b0100000, 1'b0, 0, 0, len);
    run(JL, 3'd0, 7'd0, 1'b0, 0, 0, len);
    chk("jal_cycles", len, 3);

    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, 5)];
      f3 = 3'($urandom);
      if (op == BR) f3 = {2'b00, 1'($urandom)};
      run(op, f3, 7'($urandom), 1'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 3), len);
    end

    // async reset while the load is writing back
    build(LW, 3'd2, 7'd0, 1'b0, 0, 0);
    exec(LW, 3'd2, 7'd0, 1'b0, 1);
    e = q.pop_front();
    @(posedge clk); #1; mem_ready = e.rdy;
    @(negedge clk); cyc++; compare(e);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_en",
        {pc_write, ir_write, reg_write, mem_write, mem_read}, 5'b0);
    chk("async_rst_instret", instret, 2'd0);
    cnt_m = 0; ill_m = 0; berr_m = 0;

    for (int i = 0; i < 5; i++) run(RT, 3'd4, 7'd0, 1'b0, 0, 0, len);
    run(IT, 3'd5, 7'b0100000, 1'b0, 0, 0, len);
    chk("instret_wrap", first_instret, 2'd1);

    run(7'b1111111, 3'd0, 7'd0, 1'b0, 0, 0, len);
    chk("illegal_cycles", len, 14);
    do_reset();
    run(BR, 3'd3, 7'd0, 1'b0, 1, 0, len);
    do_reset();
    run(RT, 3'd0, 7'd0, 1'b0, 4, 0, len);
    do_reset();
    run(RT, 3'd7, 7'd0, 1'b0, 3, 0, len);
    run(SW, 3'd2, 7'd0, 1'b0, 3, 3, len);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_mc_control.md
# rv32i_mc_control

Multi-cycle control unit for the RV32I core: the successor to the single-cycle `control` decoder. It sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states over a shared datapath and a single memory port with a `mem_ready` handshake. It adds branch, jump and ALU-immediate support, illegal-opcode and memory-timeout traps, and a retired-instruction counter. It sits between the instruction register and the datapath multiplexers, register file, PC and memory.

## Interface
- `MAX_WAIT`, 16: cycles `mem_ready` may stay low in a memory state before a bus-error trap; must be at least 1.
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `op_code`  in  7  instruction bits [6:0] from the instruction register.
- `func3`  in  3  instruction bits [14:12].
- `func7`  in  7  instruction bits [31:25].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `pc_write`, `ir_write`, `reg_write`, `mem_write`, `mem_read`  out  1  datapath enables.
- `adr_src`  out  1  memory address source: 0 = PC, 1 = ALUOut.
- `alu_src_a`  out  2  ALU operand A: 00 = PC, 01 = oldPC, 10 = rs1.
- `alu_src_b`  out  2  ALU operand B: 00 = rs2, 01 = imm, 10 = constant 4.
- `result_src`  out  2  result source: 00 = ALUOut, 01 = memory data, 10 = live ALU result.
- `imm_type`  out  3  immediate format: I = 000, S = 001, B = 010, J = 011.
- `alu_control`  out  4  ALU operation: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
- `illegal`, `bus_error`  out  1  sticky trap flags.
- `instret`  out  CNT_W  count of retired instructions.

## Operation
- Supported opcodes:
  - LW 0000011
  - SW 0100011
  - R-type 0110011
  - I-ALU 0010011
  - Branch 1100011 (func3 000 = BEQ, 001 = BNE)
  - JAL 1101111
- Any other opcode, or a branch with any other func3, is illegal.
- FETCH:
  - `mem_read` = 1, `adr_src` = 0, `alu_src_a` = 00, `alu_src_b` = 10, `result_src` = 10, ALU ADD.
  - When `mem_ready` = 1: `ir_write` = 1 and `pc_write` = 1 (Mealy, same cycle), next state DECODE.
- DECODE: `alu_src_a` = 01, `alu_src_b` = 01, `imm_type` = B, ADD, which stores the branch target into ALUOut. Next state by opcode: LW or SW → MEM_ADDR, R-type → EXEC_R, I-ALU → EXEC_I, Branch → BRANCH, JAL → JAL, otherwise → TRAP with `illegal` set.
- MEM_ADDR: rs1 + imm, ADD; `imm_type` = I for LW, S for SW. Next state MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: `mem_read` = 1, `adr_src` = 1. Advances to MEM_WB on `mem_ready`.
- MEM_WB: `result_src` = 01, `reg_write` = 1. Next state FETCH.
- MEM_WRITE: `mem_write` = 1, `adr_src` = 1. Advances to FETCH on `mem_ready`.
- EXEC_R, EXEC_I: rs1 op rs2 or rs1 op imm (I format). `alu_control` comes from `func3`/`func7`. `func7[5]` selects SUB only for R-type; it selects SRA for both types. Next state ALU_WB.
- ALU_WB: `result_src` = 00, `reg_write` = 1. Next state FETCH.
- BRANCH: rs1 − rs2 (SUB), `result_src` = 00, `pc_write` = `zero` XOR `func3[0]` (Mealy). Next state FETCH.
- JAL:
  - `alu_src_a` = 01, `alu_src_b` = 10, ADD, `result_src` = 00, `reg_write` = 1, `pc_write` = 1.
  - PC ← ALUOut, i.e. the target computed in DECODE with `imm_type` = J. `imm_type` = J is also driven in DECODE for JAL.
  - Next state FETCH.
- TRAP: all enables 0. Absorbing until reset.
- Wait counter:
  - Increments each cycle the block is in FETCH, MEM_READ or MEM_WRITE with `mem_ready` = 0, and clears on any state change.
  - When the count reaches `MAX_WAIT` with `mem_ready` still 0, next state is TRAP and `bus_error` is set.
  - If `mem_ready` rises in the same cycle the count reaches `MAX_WAIT`, the access completes normally.
- `instret` increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB, BRANCH or JAL. It wraps modulo 2^CNT_W.
- Unless stated otherwise, outputs default to: enables 0, select fields 00, `imm_type` 000, `alu_control` ADD.

## Timing
- While `rst` = 1: state FETCH, counters 0, `illegal` = `bus_error` = 0. All five enables are forced to 0 asynchronously. This applies mid-instruction too; no partial writes complete.
- First FETCH access begins on the first rising edge after `rst` falls.
- Minimum cycle counts with `mem_ready` tied to 1:
  - LW: 5
  - SW: 4
  - R-type and I-ALU: 4
  - BRANCH: 3
  - JAL: 3
- Each wait cycle adds 1 per memory state.
- `illegal` and `bus_error` assert on the cycle TRAP is entered and stay high until reset.

## Structure
- `rv32i_pkg` holds: opcode constants, the state enum, the `alu_control` codes, the `imm_type` codes, and the select encodings.
- Sub-module `alu_decoder`: combinational; maps `func3`, `func7[5]` and the instruction class to `alu_control`. The FSM, wait counter and `instret` stay in the top-level module.

## Test plan
- `mem_ready` = 1, LW (0000011) → states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; `imm_type` = 000; `reg_write` = 1 only in MEM_WB; `instret` 0 → 1.
- SW with `mem_ready` low for 3 cycles in MEM_WRITE → `mem_write` high for 4 cycles; 7 cycles in total; no trap.
- BEQ with `zero` = 1 → `pc_write` = 1 in BRANCH. BNE with `zero` = 1 → `pc_write` = 0. R-type SUB (func7 = 0100000, func3 = 000) → `alu_control` = 0001. I-ALU with func7 = 0100000, func3 = 000 → ADD.
- `op_code` 1111111 → TRAP after DECODE, `illegal` = 1, enables 0 for 10 or more subsequent cycles; `rst` clears the trap.
- `MAX_WAIT` = 4, `mem_ready` held at 0 in FETCH → `bus_error` asserts on the 5th cycle. A second run with `mem_ready` rising on the 4th wait cycle → normal fetch.
- `rst` pulsed asynchronously during MEM_WB → `reg_write` drops immediately, state FETCH; `CNT_W` = 2 with 5 retired instructions → `instret` = 1.
